// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared Y86-64 encodings and controller state type for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    typedef enum logic [2:0] {
        CS_IDLE  = 3'd0,
        CS_RUN   = 3'd1,
        CS_PAUSE = 3'd2,
        CS_STEP  = 3'd3,
        CS_HALT  = 3'd4
    } state_t;

    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Counter that increments on en and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller for the 5-stage Y86-64 pipe with a run/pause/step/halt
// bring-up FSM and saturating performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             step_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [3:0]       W_icode_i,
    input  logic [2:0]       W_stat_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             E_stall_o,
    output logic             M_stall_o,
    output logic             W_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic [2:0]       state_o,
    output logic [2:0]       halt_stat_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_t state;
    logic   active;
    logic   lu, ret_h, mp, mx, wx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= CS_IDLE;
            halt_stat_o <= SAOK;
        end else begin
            case (state)
                CS_IDLE: begin
                    if (start_i) state <= CS_RUN;
                end
                CS_RUN: begin
                    // Any non-AOK writeback status stops the core, even with pause requested.
                    if (W_stat_i != SAOK) begin
                        state       <= CS_HALT;
                        halt_stat_o <= W_stat_i;
                    end else if (pause_i) begin
                        state <= CS_PAUSE;
                    end
                end
                CS_PAUSE: begin
                    if (start_i)     state <= CS_RUN;
                    else if (step_i) state <= CS_STEP;
                end
                CS_STEP: begin
                    if (W_stat_i != SAOK) begin
                        state       <= CS_HALT;
                        halt_stat_o <= W_stat_i;
                    end else begin
                        state <= CS_PAUSE;
                    end
                end
                default: state <= CS_HALT;
            endcase
        end
    end

    assign state_o = state;
    assign active  = (state == CS_RUN) || (state == CS_STEP);

    assign lu    = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) && (E_dstM_i != RNONE)
                   && ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    assign ret_h = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    assign mp    = (E_icode_i == IJXX) && !e_Cnd_i;
    assign mx    = is_exc(m_stat_i);
    assign wx    = is_exc(W_stat_i);

    // Frozen states hold every stage and keep bubbles low, since a stage honours bubble over stall.
    always_comb begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_stall_o  = 1'b1;
        M_stall_o  = 1'b1;
        W_stall_o  = 1'b1;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        if (active) begin
            F_stall_o  = lu | ret_h;
            D_stall_o  = lu;
            E_stall_o  = 1'b0;
            M_stall_o  = 1'b0;
            W_stall_o  = wx;
            D_bubble_o = mp | (ret_h & ~lu);
            E_bubble_o = mp | lu;
            M_bubble_o = mx | wx;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (active),
        .q     (cycle_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (active && (W_icode_i != INOP) && (W_stat_i == SAOK) && !W_stall_o),
        .q     (retire_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (active && F_stall_o),
        .q     (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Vector-table bench for pipe_hazard_ctrl: a wide-counter instance and a 4-bit-counter
// instance share stimulus so saturation is reachable in a short run.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int CW = 16;
    localparam logic [7:0] FROZEN = 8'b11111000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start, pause, step, e_cnd;
    logic [3:0] d_icode, d_srca, d_srcb, e_icode, e_dstm, m_icode, w_icode;
    logic [2:0] m_stat, w_stat;

    logic f_st, d_st, e_st, m_st, w_st, d_bb, e_bb, m_bb;
    logic [2:0] state, halt_stat;
    logic [CW-1:0] cyc, ret, stl;
    logic s_f_st, s_d_st, s_e_st, s_m_st, s_w_st, s_d_bb, s_e_bb, s_m_bb;
    logic [2:0] s_state, s_halt_stat;
    logic [3:0] s_cyc, s_ret, s_stl;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pause_i(pause), .step_i(step),
        .D_icode_i(d_icode), .d_srcA_i(d_srca), .d_srcB_i(d_srcb), .E_icode_i(e_icode),
        .E_dstM_i(e_dstm), .e_Cnd_i(e_cnd), .M_icode_i(m_icode), .m_stat_i(m_stat),
        .W_icode_i(w_icode), .W_stat_i(w_stat),
        .F_stall_o(f_st), .D_stall_o(d_st), .E_stall_o(e_st), .M_stall_o(m_st), .W_stall_o(w_st),
        .D_bubble_o(d_bb), .E_bubble_o(e_bb), .M_bubble_o(m_bb),
        .state_o(state), .halt_stat_o(halt_stat),
        .cycle_cnt_o(cyc), .retire_cnt_o(ret), .stall_cnt_o(stl)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_w4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pause_i(pause), .step_i(step),
        .D_icode_i(d_icode), .d_srcA_i(d_srca), .d_srcB_i(d_srcb), .E_icode_i(e_icode),
        .E_dstM_i(e_dstm), .e_Cnd_i(e_cnd), .M_icode_i(m_icode), .m_stat_i(m_stat),
        .W_icode_i(w_icode), .W_stat_i(w_stat),
        .F_stall_o(s_f_st), .D_stall_o(s_d_st), .E_stall_o(s_e_st), .M_stall_o(s_m_st),
        .W_stall_o(s_w_st), .D_bubble_o(s_d_bb), .E_bubble_o(s_e_bb), .M_bubble_o(s_m_bb),
        .state_o(s_state), .halt_stat_o(s_halt_stat),
        .cycle_cnt_o(s_cyc), .retire_cnt_o(s_ret), .stall_cnt_o(s_stl)
    );

    typedef struct {
        string      name;
        logic       start, pause, step, e_cnd;
        logic [3:0] d_icode, d_srca, d_srcb, e_icode, e_dstm, m_icode, w_icode;
        logic [2:0] m_stat, w_stat;
        logic [2:0] exp_state;
        logic [7:0] exp_ctl;   // {F,D,E,M,W stall, D,E,M bubble}
    } vec_t;

    vec_t vecs[21];
    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int exp_cyc = 0, exp_ret = 0, exp_stl = 0;

    function automatic vec_t mk(input string name, input logic [2:0] st, input logic [7:0] ctl);
        vec_t v;
        v.name = name; v.start = 1'b0; v.pause = 1'b0; v.step = 1'b0; v.e_cnd = 1'b1;
        v.d_icode = INOP; v.d_srca = RNONE; v.d_srcb = RNONE; v.e_icode = INOP; v.e_dstm = RNONE;
        v.m_icode = INOP; v.w_icode = INOP; v.m_stat = SAOK; v.w_stat = SAOK;
        v.exp_state = st; v.exp_ctl = ctl;
        return v;
    endfunction

    function automatic int sat4(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_counters();
        check("cycle_cnt", 32'(cyc), 32'(exp_cyc));
        check("retire_cnt", 32'(ret), 32'(exp_ret));
        check("stall_cnt", 32'(stl), 32'(exp_stl));
        check("cycle_cnt_w4", 32'(s_cyc), 32'(sat4(exp_cyc)));
        check("retire_cnt_w4", 32'(s_ret), 32'(sat4(exp_ret)));
        check("stall_cnt_w4", 32'(s_stl), 32'(sat4(exp_stl)));
    endtask

    // Drive at posedge+1, compare at the negedge, then advance the counter model for the coming edge.
    task automatic apply(input vec_t v);
        logic [10:0] exp;
        start = v.start; pause = v.pause; step = v.step; e_cnd = v.e_cnd;
        d_icode = v.d_icode; d_srca = v.d_srca; d_srcb = v.d_srcb; e_icode = v.e_icode;
        e_dstm = v.e_dstm; m_icode = v.m_icode; w_icode = v.w_icode;
        m_stat = v.m_stat; w_stat = v.w_stat;
        exp_q.push_back({v.exp_state, v.exp_ctl});
        @(negedge clk);
        check_counters();
        exp = exp_q.pop_front();
        check(v.name, {21'd0, state, f_st, d_st, e_st, m_st, w_st, d_bb, e_bb, m_bb}, {21'd0, exp});
        if (v.exp_state == 3'd1 || v.exp_state == 3'd3) begin
            exp_cyc++;
            if (v.exp_ctl[7]) exp_stl++;
            if (v.w_icode != INOP && v.w_stat == SAOK && !v.exp_ctl[3]) exp_ret++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        vecs[0]  = mk("idle_start", 3'd0, FROZEN);     vecs[0].start = 1'b1;
        vecs[1]  = mk("run_clean", 3'd1, 8'b00000000);
        vecs[2]  = mk("run_retire", 3'd1, 8'b00000000); vecs[2].w_icode = IOPQ;
        vecs[3]  = mk("load_use_srca", 3'd1, 8'b11000010);
        vecs[3].e_icode = IMRMOVQ; vecs[3].e_dstm = 4'd3; vecs[3].d_srca = 4'd3;
        vecs[4]  = mk("load_use_rnone", 3'd1, 8'b00000000);
        vecs[4].e_icode = IMRMOVQ; vecs[4].e_dstm = RNONE; vecs[4].d_srca = 4'd3;
        vecs[5]  = mk("load_use_popq_srcb", 3'd1, 8'b11000010);
        vecs[5].e_icode = IPOPQ; vecs[5].e_dstm = 4'd4; vecs[5].d_srcb = 4'd4; vecs[5].w_icode = IOPQ;
        vecs[6]  = mk("mispredict", 3'd1, 8'b00000110);
        vecs[6].e_icode = IJXX; vecs[6].e_cnd = 1'b0;
        vecs[7]  = mk("mispredict_ret_d", 3'd1, 8'b10000110);
        vecs[7].e_icode = IJXX; vecs[7].e_cnd = 1'b0; vecs[7].d_icode = IRET;
        vecs[8]  = mk("jxx_taken", 3'd1, 8'b00000000);
        vecs[8].e_icode = IJXX; vecs[8].e_cnd = 1'b1;
        vecs[9]  = mk("ret_in_m", 3'd1, 8'b10000100);  vecs[9].m_icode = IRET;
        vecs[10] = mk("ret_and_load_use", 3'd1, 8'b11000010);
        vecs[10].e_icode = IMRMOVQ; vecs[10].e_dstm = 4'd2; vecs[10].d_srcb = 4'd2;
        vecs[10].d_icode = IRET;
        vecs[11] = mk("mem_exception", 3'd1, 8'b00000001); vecs[11].m_stat = SADR;
        vecs[12] = mk("pause_req", 3'd1, 8'b00000000);  vecs[12].pause = 1'b1;
        vecs[13] = mk("paused_hazard", 3'd2, FROZEN);
        vecs[13].e_icode = IJXX; vecs[13].e_cnd = 1'b0; vecs[13].w_icode = IOPQ;
        vecs[14] = mk("step_req", 3'd2, FROZEN);         vecs[14].step = 1'b1;
        vecs[15] = mk("step_cycle", 3'd3, 8'b00000000); vecs[15].w_icode = IOPQ;
        vecs[16] = mk("after_step", 3'd2, FROZEN);       vecs[16].start = 1'b1;
        vecs[17] = mk("run_again", 3'd1, 8'b00000000);
        vecs[18] = mk("wstat_adr_pause", 3'd1, 8'b00001001);
        vecs[18].w_stat = SADR; vecs[18].w_icode = IOPQ; vecs[18].pause = 1'b1;
        vecs[19] = mk("halted", 3'd4, FROZEN);           vecs[19].start = 1'b1;
        vecs[20] = mk("halted_hold", 3'd4, FROZEN);      vecs[20].step = 1'b1;

        // Reset with quiet inputs.
        v = mk("reset", 3'd0, FROZEN);
        start = 1'b0; pause = 1'b0; step = 1'b0; e_cnd = 1'b1;
        d_icode = INOP; d_srca = RNONE; d_srcb = RNONE; e_icode = INOP; e_dstm = RNONE;
        m_icode = INOP; w_icode = INOP; m_stat = SAOK; w_stat = SAOK;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctl", {24'd0, f_st, d_st, e_st, m_st, w_st, d_bb, e_bb, m_bb}, 32'(FROZEN));
        check("reset_halt_stat", 32'(halt_stat), 32'(SAOK));
        check_counters();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i <= 13; i++) apply(vecs[i]);
        // Held in PAUSE with no requests: counters must not move.
        for (int i = 0; i < 10; i++) apply(mk("pause_hold", 3'd2, FROZEN));
        for (int i = 14; i <= 20; i++) apply(vecs[i]);
        @(negedge clk);
        check("halt_stat", 32'(halt_stat), 32'(SADR));
        check("halt_stat_w4", 32'(s_halt_stat), 32'(SADR));
        check_counters();
        @(posedge clk); #1;

        // Fresh run long enough to pin the 4-bit cycle counter at all-ones.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        exp_cyc = 0; exp_ret = 0; exp_stl = 0;
        @(posedge clk); #1;
        v = mk("sat_start", 3'd0, FROZEN); v.start = 1'b1;
        apply(v);
        for (int i = 0; i < 20; i++) begin
            v = mk("sat_run", 3'd1, 8'b00000000);
            v.w_icode = IOPQ;
            if ($urandom_range(0, 1) == 1) v.m_icode = IRET;
            if (v.m_icode == IRET) v.exp_ctl = 8'b10000100;
            apply(v);
        end
        @(negedge clk);
        check("sat_cycle_w4", 32'(s_cyc), 32'd15);
        check("sat_retire_w4", 32'(s_ret), 32'd15);
        check("cycle_after_sat", 32'(cyc), 32'd20);
        @(posedge clk); #2;

        // Asynchronous reset mid-RUN clears state and counters before the next edge.
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_cycle", 32'(cyc), 32'd0);
        check("async_rst_retire", 32'(ret), 32'd0);
        check("async_rst_stall_w4", 32'(s_stl), 32'd0);
        check("async_rst_cycle_w4", 32'(s_cyc), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
